// File: rtl/intersection_ctrl.sv
// intersection_ctrl: six-phase two-direction intersection sequencer.
// Drives the NS and EW lamp sets through
//   NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G
// with programmable green/yellow/all-red durations and per-direction
// pedestrian request/acknowledge handshakes that stretch a green to at
// least WALK_MIN cycles while walk is shown.
// Ports:
//   clk                     rising-edge clock
//   reset                   synchronous, active-low
//   set                     load durations, restart at NS green
//   stop                    freeze phase and counter
//   g_time/y_time/ar_time   phase durations (0 is stored as 1)
//   ped_req_ns/ped_req_ew   pedestrian request levels (rising edge counts)
//   ns_g/ns_y/ns_r          NS lamps
//   ew_g/ew_y/ew_r          EW lamps
//   walk_ns/walk_ew         walk indication for the whole served green
//   ped_ack_ns/ped_ack_ew   one-cycle acknowledge on served green entry
//   phase                   current phase code (IDLE=0 .. AR2=6)
module intersection_ctrl #(
  parameter int CW       = 4,
  parameter int WALK_MIN = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          stop,
  input  logic [CW-1:0] g_time,
  input  logic [CW-1:0] y_time,
  input  logic [CW-1:0] ar_time,
  input  logic          ped_req_ns,
  input  logic          ped_req_ew,
  output logic          ns_g,
  output logic          ns_y,
  output logic          ns_r,
  output logic          ew_g,
  output logic          ew_y,
  output logic          ew_r,
  output logic          walk_ns,
  output logic          walk_ew,
  output logic          ped_ack_ns,
  output logic          ped_ack_ew,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    AR1     = 3'd3,
    EW_G    = 3'd4,
    EW_Y    = 3'd5,
    AR2     = 3'd6,
    ILLEGAL = 3'd7
  } phase_t;

  localparam logic [CW-1:0] WALK_W = CW'(WALK_MIN);
  localparam logic [CW-1:0] ONE    = CW'(1);

  function automatic logic [CW-1:0] nz(input logic [CW-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  phase_t        st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] g_cfg, y_cfg, ar_cfg;
  logic [CW-1:0] g_nx, y_nx, ar_nx, g_walk;
  logic          req_ns_q, req_ew_q, rise_ns, rise_ew;
  logic          pend_ns, pend_ew, pend_ns_nx, pend_ew_nx;
  logic          walk_ns_nx, walk_ew_nx, ack_ns_nx, ack_ew_nx;
  logic          active, ns_entry, ew_entry;
  logic          ns_g_nx, ns_y_nx, ns_r_nx, ew_g_nx, ew_y_nx, ew_r_nx;

  always_comb begin
    rise_ns = ped_req_ns & ~req_ns_q;
    rise_ew = ped_req_ew & ~req_ew_q;
    active  = (st != IDLE) && (st != ILLEGAL);

    // A set this cycle uses the freshly loaded durations immediately.
    g_nx   = set ? nz(g_time)  : g_cfg;
    y_nx   = set ? nz(y_time)  : y_cfg;
    ar_nx  = set ? nz(ar_time) : ar_cfg;
    g_walk = (g_nx < WALK_W) ? WALK_W : g_nx;

    st_nx      = st;
    cnt_nx     = cnt;
    pend_ns_nx = pend_ns | (active & rise_ns);
    pend_ew_nx = pend_ew | (active & rise_ew);
    walk_ns_nx = walk_ns;
    walk_ew_nx = walk_ew;
    ack_ns_nx  = 1'b0;
    ack_ew_nx  = 1'b0;
    ns_entry   = 1'b0;
    ew_entry   = 1'b0;

    if (set) begin
      ns_entry = 1'b1;
    end else begin
      case (st)
        IDLE: ;
        NS_G, NS_Y, AR1, EW_G, EW_Y, AR2: begin
          if (!stop) begin
            if (cnt == ONE) begin
              case (st)
                NS_G:    begin st_nx = NS_Y; cnt_nx = y_nx;  end
                NS_Y:    begin st_nx = AR1;  cnt_nx = ar_nx; end
                AR1:     ew_entry = 1'b1;
                EW_G:    begin st_nx = EW_Y; cnt_nx = y_nx;  end
                EW_Y:    begin st_nx = AR2;  cnt_nx = ar_nx; end
                AR2:     ns_entry = 1'b1;
                default: ;
              endcase
            end else begin
              cnt_nx = cnt - ONE;
            end
          end
        end
        default: begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end
      endcase
    end

    // Green entry consumes a pending request or a same-cycle rising edge.
    if (ns_entry) begin
      st_nx = NS_G;
      if (pend_ns | rise_ns) begin
        cnt_nx     = g_walk;
        pend_ns_nx = 1'b0;
        ack_ns_nx  = 1'b1;
        walk_ns_nx = 1'b1;
      end else begin
        cnt_nx     = g_nx;
        walk_ns_nx = 1'b0;
      end
    end
    if (ew_entry) begin
      st_nx = EW_G;
      if (pend_ew | rise_ew) begin
        cnt_nx     = g_walk;
        pend_ew_nx = 1'b0;
        ack_ew_nx  = 1'b1;
        walk_ew_nx = 1'b1;
      end else begin
        cnt_nx     = g_nx;
        walk_ew_nx = 1'b0;
      end
    end

    // Walk survives only while its own green persists.
    if (st_nx != NS_G) walk_ns_nx = 1'b0;
    if (st_nx != EW_G) walk_ew_nx = 1'b0;

    ns_g_nx = (st_nx == NS_G);
    ns_y_nx = (st_nx == NS_Y);
    ns_r_nx = (st_nx == AR1) || (st_nx == EW_G) || (st_nx == EW_Y) || (st_nx == AR2);
    ew_g_nx = (st_nx == EW_G);
    ew_y_nx = (st_nx == EW_Y);
    ew_r_nx = (st_nx == NS_G) || (st_nx == NS_Y) || (st_nx == AR1) || (st_nx == AR2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      cnt        <= '0;
      g_cfg      <= ONE;
      y_cfg      <= ONE;
      ar_cfg     <= ONE;
      req_ns_q   <= 1'b0;
      req_ew_q   <= 1'b0;
      pend_ns    <= 1'b0;
      pend_ew    <= 1'b0;
      walk_ns    <= 1'b0;
      walk_ew    <= 1'b0;
      ped_ack_ns <= 1'b0;
      ped_ack_ew <= 1'b0;
      ns_g       <= 1'b0;
      ns_y       <= 1'b0;
      ns_r       <= 1'b0;
      ew_g       <= 1'b0;
      ew_y       <= 1'b0;
      ew_r       <= 1'b0;
    end else begin
      st         <= st_nx;
      cnt        <= cnt_nx;
      g_cfg      <= g_nx;
      y_cfg      <= y_nx;
      ar_cfg     <= ar_nx;
      req_ns_q   <= ped_req_ns;
      req_ew_q   <= ped_req_ew;
      pend_ns    <= pend_ns_nx;
      pend_ew    <= pend_ew_nx;
      walk_ns    <= walk_ns_nx;
      walk_ew    <= walk_ew_nx;
      ped_ack_ns <= ack_ns_nx;
      ped_ack_ew <= ack_ew_nx;
      ns_g       <= ns_g_nx;
      ns_y       <= ns_y_nx;
      ns_r       <= ns_r_nx;
      ew_g       <= ew_g_nx;
      ew_y       <= ew_y_nx;
      ew_r       <= ew_r_nx;
    end
  end

  assign phase = st;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: self-checking bench for intersection_ctrl.
// Table vectors for reset/idle and the first full cycle, hand sequences
// for stop, zero durations, pedestrian walks and set/reset interaction,
// then randomized stimulus against a behavioural schedule model.
module tb_intersection_ctrl;
  localparam int CW       = 4;
  localparam int WALK_MIN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, set, stop, ped_req_ns, ped_req_ew;
  logic [CW-1:0] g_time, y_time, ar_time;
  logic          ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic          walk_ns, walk_ew, ped_ack_ns, ped_ack_ew;
  logic [2:0]    phase;

  intersection_ctrl #(.CW(CW), .WALK_MIN(WALK_MIN)) dut (
    .clk(clk), .reset(reset), .set(set), .stop(stop),
    .g_time(g_time), .y_time(y_time), .ar_time(ar_time),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .walk_ns(walk_ns), .walk_ew(walk_ew),
    .ped_ack_ns(ped_ack_ns), .ped_ack_ew(ped_ack_ew),
    .phase(phase)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Schedule model: segment 0..5 of the cycle, elapsed cycles counted up
  // against the duration chosen on entry.
  int m_active, m_seg, m_el, m_dur, m_g, m_y, m_ar;
  bit m_pend[2], m_prev[2], m_walk[2], m_ack[2], m_rise[2];

  function automatic int nzi(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic m_green(input int d);
    if (m_pend[d] || m_rise[d]) begin
      m_dur     = (m_g > WALK_MIN) ? m_g : WALK_MIN;
      m_pend[d] = 0;
      m_ack[d]  = 1;
      m_walk[d] = 1;
    end else begin
      m_dur = m_g;
    end
  endtask

  task automatic m_enter(input int s);
    m_seg = s;
    m_el  = 0;
    m_walk[0] = 0;
    m_walk[1] = 0;
    case (s)
      0:       m_green(0);
      3:       m_green(1);
      1, 4:    m_dur = m_y;
      default: m_dur = m_ar;
    endcase
  endtask

  task automatic model_step();
    bit req[2];
    req[0] = ped_req_ns;
    req[1] = ped_req_ew;
    if (!reset) begin
      m_active = 0; m_seg = 0; m_el = 0; m_dur = 0;
      m_g = 1; m_y = 1; m_ar = 1;
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = 0; m_prev[d] = 0; m_walk[d] = 0; m_ack[d] = 0; m_rise[d] = 0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_rise[d] = req[d] && !m_prev[d];
      m_prev[d] = req[d];
      m_ack[d]  = 0;
      if (m_active != 0 && m_rise[d]) m_pend[d] = 1;
    end
    if (set) begin
      m_g = nzi(int'(g_time)); m_y = nzi(int'(y_time)); m_ar = nzi(int'(ar_time));
      m_active = 1;
      m_enter(0);
    end else if (m_active != 0 && !stop) begin
      m_el++;
      if (m_el >= m_dur) m_enter((m_seg + 1) % 6);
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [5:0] l;
    int ph;
    if (m_active == 0) return '0;
    ph = m_seg + 1;
    l[5] = (m_seg == 0);
    l[4] = (m_seg == 1);
    l[3] = (m_seg >= 2);
    l[2] = (m_seg == 3);
    l[1] = (m_seg == 4);
    l[0] = (m_seg <= 2) || (m_seg == 5);
    return {3'(ph), l, m_walk[0], m_walk[1], m_ack[0], m_ack[1]};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r,
            walk_ns, walk_ew, ped_ack_ns, ped_ack_ew};
  endfunction

  task automatic tick_raw();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_raw();
    check("model", int'(dut_vec()), int'(exp_vec()));
  endtask

  task automatic wait_phase(input int p, input int budget);
    int guard = 0;
    while (int'(phase) != p && guard < budget) begin
      tick();
      guard++;
    end
    if (int'(phase) != p) check("wait_phase_timeout", int'(phase), p);
  endtask

  // Length of the green currently shown, with walk and ack cycle counts.
  task automatic measure(input int p, output int len, output int wk, output int ak);
    int guard = 0;
    len = 0; wk = 0; ak = 0;
    while (int'(phase) == p && guard < 40) begin
      len++;
      wk += (p == 1) ? int'(walk_ns) : int'(walk_ew);
      ak += (p == 1) ? int'(ped_ack_ns) : int'(ped_ack_ew);
      tick();
      guard++;
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         st;
    bit         sp;
    int         ph;
    logic [5:0] lamps;
  } vec_t;

  localparam logic [5:0] OFF = 6'b000000, NSG = 6'b100001, NSY = 6'b010001,
                         ARL = 6'b001001, EWG = 6'b001100, EWY = 6'b001010;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, wk, ak, ewg_cnt, guard;
    logic [12:0] e;
    int zexp[6];

    tbl[0]  = '{0, 0, 0, 0, OFF};
    tbl[1]  = '{0, 0, 0, 0, OFF};
    tbl[2]  = '{1, 0, 1, 0, OFF};
    tbl[3]  = '{1, 0, 0, 0, OFF};
    tbl[4]  = '{1, 0, 1, 0, OFF};
    tbl[5]  = '{1, 1, 0, 1, NSG};
    tbl[6]  = '{1, 0, 0, 1, NSG};
    tbl[7]  = '{1, 0, 0, 1, NSG};
    tbl[8]  = '{1, 0, 0, 2, NSY};
    tbl[9]  = '{1, 0, 0, 2, NSY};
    tbl[10] = '{1, 0, 0, 3, ARL};
    tbl[11] = '{1, 0, 0, 4, EWG};
    tbl[12] = '{1, 0, 0, 4, EWG};
    tbl[13] = '{1, 0, 0, 4, EWG};
    tbl[14] = '{1, 0, 0, 5, EWY};
    tbl[15] = '{1, 0, 0, 5, EWY};
    tbl[16] = '{1, 0, 0, 6, ARL};
    tbl[17] = '{1, 0, 0, 1, NSG};

    reset = 0; set = 0; stop = 0; ped_req_ns = 0; ped_req_ew = 0;
    g_time = 4'd3; y_time = 4'd2; ar_time = 4'd1;

    foreach (tbl[i]) begin
      reset = tbl[i].rst_n;
      set   = tbl[i].st;
      stop  = tbl[i].sp;
      tick_raw();
      e = {3'(tbl[i].ph), tbl[i].lamps, 4'b0000};
      check($sformatf("vec%0d", i), int'(dut_vec()), int'(e));
    end

    // Stop held 5 cycles starting in the 2nd cycle of EW_G.
    wait_phase(4, 20);
    ewg_cnt = int'(ew_g);
    tick();
    ewg_cnt += int'(ew_g);
    stop = 1;
    repeat (5) begin
      tick();
      ewg_cnt += int'(ew_g);
    end
    stop = 0;
    guard = 0;
    while (ew_g && guard < 20) begin
      tick();
      ewg_cnt += int'(ew_g);
      guard++;
    end
    check("stop_ewg_len", ewg_cnt, 8);
    check("stop_then_ewy", int'(phase), 5);

    // All-zero durations: every phase one cycle, period 6.
    g_time = 0; y_time = 0; ar_time = 0;
    set = 1; tick(); set = 0;
    check("zero_set", int'(phase), 1);
    zexp = '{2, 3, 4, 5, 6, 1};
    foreach (zexp[k]) begin
      tick();
      check("zero_dur", int'(phase), zexp[k]);
    end

    // NS walk: request during EW_Y, served at the next NS_G.
    g_time = 3; y_time = 2; ar_time = 1;
    set = 1; tick(); set = 0;
    wait_phase(5, 30);
    ped_req_ns = 1;
    wait_phase(1, 30);
    check("ns_ack_first", int'(ped_ack_ns), 1);
    measure(1, len, wk, ak);
    check("ns_walk_len", len, WALK_MIN);
    check("ns_walk_cnt", wk, WALK_MIN);
    check("ns_ack_cnt", ak, 1);
    check("ns_walk_off", int'(walk_ns), 0);
    ped_req_ns = 0;
    wait_phase(1, 30);
    measure(1, len, wk, ak);
    check("ns_plain_len", len, 3);
    check("ns_plain_walk", wk, 0);

    // EW walk: request during NS_Y.
    wait_phase(2, 30);
    ped_req_ew = 1;
    wait_phase(4, 30);
    measure(4, len, wk, ak);
    check("ew_walk_len", len, WALK_MIN);
    check("ew_walk_cnt", wk, WALK_MIN);
    check("ew_ack_cnt", ak, 1);
    ped_req_ew = 0;
    wait_phase(4, 30);
    measure(4, len, wk, ak);
    check("ew_plain_len", len, 3);
    check("ew_plain_walk", wk, 0);

    // Set mid NS_Y restarts NS_G at full count; reset mid EW_G clears pending.
    wait_phase(2, 30);
    set = 1; tick(); set = 0;
    check("set_restart", int'(phase), 1);
    measure(1, len, wk, ak);
    check("set_ns_len", len, 3);
    wait_phase(4, 30);
    ped_req_ns = 1;
    tick();
    reset = 0; ped_req_ns = 0;
    tick();
    check("reset_clear", int'(dut_vec()), 0);
    reset = 1;
    tick();
    check("idle_after_reset", int'(phase), 0);
    set = 1; tick(); set = 0;
    measure(1, len, wk, ak);
    check("no_stale_len", len, 3);
    check("no_stale_walk", wk, 0);
    check("no_stale_ack", ak, 0);

    // Randomized stimulus against the model.
    set = 1; tick(); set = 0;
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 249) != 0);
      set     = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 7) == 0);
      g_time  = CW'($urandom_range(0, 15));
      y_time  = CW'($urandom_range(0, 15));
      ar_time = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) ped_req_ns = ~ped_req_ns;
      if ($urandom_range(0, 5) == 0) ped_req_ew = ~ped_req_ew;
      if (!reset && $urandom_range(0, 1) == 0) set = 1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
